xaddrgen_seq: RTL and testbench
===============================

Name: xaddrgen_seq

Overview:
- Configuration sequencer for one xaddrgen instance.
- Holds a queue of up to DEPTH address-generator configurations written by the host/controller. On a go command, it drives each configuration into the address generator in turn: it pulses init, then run, then waits for the generator's done.
- Lets software chain several access patterns (e.g. tiled reads) without polling between them. Sits between the control register file and the memory unit's xaddrgen.

Parameters:
- MEM_ADDR_W, 10, address/iteration field width (matches xaddrgen)
- PERIOD_W, 10, period/duty/delay field width (matches xaddrgen)
- DEPTH, 4, configuration queue entries; power of two, >=2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_valid  in  1  push request for one configuration
- cfg_ready  out  1  queue not full; push accepted when cfg_valid&&cfg_ready at posedge
- cfg_iterations  in  MEM_ADDR_W  iterations field to push
- cfg_period  in  PERIOD_W  period field
- cfg_duty  in  PERIOD_W  duty field
- cfg_delay  in  PERIOD_W  delay field
- cfg_start  in  MEM_ADDR_W  start field
- cfg_shift  in  MEM_ADDR_W  shift field (signed)
- cfg_incr  in  MEM_ADDR_W  incr field (signed)
- go  in  1  start executing queued configurations (single-cycle pulse)
- abort  in  1  stop sequencing and flush queue
- level  out  log2(DEPTH)+1  number of queued entries
- busy  out  1  sequencer not IDLE
- seq_done  out  1  one-cycle pulse when the last queued configuration completes
- ag_iterations, ag_period, ag_duty, ag_delay, ag_start, ag_shift, ag_incr  out  field widths  registered config to xaddrgen
- ag_init  out  1  init pulse to xaddrgen
- ag_run  out  1  run pulse to xaddrgen
- ag_done  in  1  xaddrgen done

Behaviour:
- Reset (async, active-high):
  - Queue empty; level=0; cfg_ready=1.
  - State IDLE; busy=0, seq_done=0, ag_init=0, ag_run=0.
  - All ag_* fields 0.
- Queue:
  - Circular FIFO with read/write pointers one bit wider than log2(DEPTH).
  - cfg_ready = !full (combinational).
  - A push while full is ignored.
  - Push and pop in the same cycle are both performed; level is unchanged.
  - level is the pointer difference, registered.
- FSM states: IDLE, LOAD, RUN, WAIT_BUSY, WAIT_DONE.
  - IDLE: go && level!=0 -> LOAD. go with an empty queue is ignored (no seq_done). busy=0.
  - LOAD (1 cycle): ag_* fields loaded from the head entry; ag_init=1 this cycle -> RUN.
  - RUN (1 cycle): ag_run=1 -> WAIT_BUSY.
  - WAIT_BUSY: stay while ag_done=1; ag_done=0 -> WAIT_DONE.
  - WAIT_DONE: stay while ag_done=0. On ag_done=1, pop the head. If the queue is then empty (level==1 before the pop and no push this cycle), go to IDLE and pulse seq_done=1 for one cycle; otherwise go to LOAD.
- ag_* fields: registered; change only in LOAD; held stable through RUN/WAIT_* and afterward in IDLE.
- ag_init and ag_run: registered single-cycle pulses, never high in the same cycle.
- Latency:
  - go sampled at edge N -> ag_init high in cycle N+1, ag_run in N+2.
  - ag_done rising sampled at edge M -> next ag_init in cycle M+1.
  - Inter-config overhead: 2 cycles plus xaddrgen's done-deassert cycle.
- Pushes are allowed while busy. An entry pushed during WAIT_DONE before the last pop is executed within the same sequence.
- go while busy is ignored.
- abort: highest priority, any state.
  - Next state IDLE; queue flushed (level=0).
  - ag_init/ag_run forced 0; no seq_done.
  - A push in the same cycle as abort is discarded.
  - An in-flight xaddrgen run is not stopped; it finishes on its own.
- Reset mid-operation: immediate return to reset values; the queue is lost.
- Widths: fields stored verbatim; no arithmetic on config data.

Test Plan:
- Reset, then push one config (iterations=2, period=3, duty=3, delay=0, start=0x10, incr=1, shift=0), then go -> ag_init at go+1 with ag_start=0x10, ag_run at go+2. With model done rising 6 cycles later: seq_done pulses once, busy=0, level=0.
- Push 3 configs (start=0x00, 0x40, 0x80), go -> three init/run pairs in order with ag_start 0x00, 0x40, 0x80; exactly one seq_done, after the third done.
- Push DEPTH+1=5 configs back-to-back -> cfg_ready=0 after the 4th, 5th dropped, level=4.
- During WAIT_DONE of the last entry, push a 4th config (start=0xC0) -> it executes with no seq_done between; seq_done only after 0xC0 completes.
- abort during WAIT_DONE with level=3, with a simultaneous push -> IDLE next cycle, level=0, no seq_done, and no further ag_init even when ag_done later rises.
- go with empty queue -> no ag_init, busy stays 0. Assert rst mid-WAIT_BUSY -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/xaddrgen_seq_if.sv
`default_nettype none
// ============================================================================
// Module : xaddrgen_seq_if
// Brief  : Host configuration / address-generator bus of the xaddrgen sequencer.
// Rev    : 1.0
// ============================================================================
interface xaddrgen_seq_if #(
    parameter int MEM_ADDR_W = 10,
    parameter int PERIOD_W   = 10,
    parameter int DEPTH      = 4
);
    localparam int c_LW = $clog2(DEPTH) + 1;

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [MEM_ADDR_W-1:0] cfg_iterations;
    logic [PERIOD_W-1:0]   cfg_period;
    logic [PERIOD_W-1:0]   cfg_duty;
    logic [PERIOD_W-1:0]   cfg_delay;
    logic [MEM_ADDR_W-1:0] cfg_start;
    logic [MEM_ADDR_W-1:0] cfg_shift;
    logic [MEM_ADDR_W-1:0] cfg_incr;
    logic                  go;
    logic                  abort;
    logic [c_LW-1:0]       level;
    logic                  busy;
    logic                  seq_done;
    logic [MEM_ADDR_W-1:0] ag_iterations;
    logic [PERIOD_W-1:0]   ag_period;
    logic [PERIOD_W-1:0]   ag_duty;
    logic [PERIOD_W-1:0]   ag_delay;
    logic [MEM_ADDR_W-1:0] ag_start;
    logic [MEM_ADDR_W-1:0] ag_shift;
    logic [MEM_ADDR_W-1:0] ag_incr;
    logic                  ag_init;
    logic                  ag_run;
    logic                  ag_done;

    modport slave (
        input  cfg_valid, cfg_iterations, cfg_period, cfg_duty, cfg_delay,
               cfg_start, cfg_shift, cfg_incr, go, abort, ag_done,
        output cfg_ready, level, busy, seq_done, ag_iterations, ag_period,
               ag_duty, ag_delay, ag_start, ag_shift, ag_incr, ag_init, ag_run
    );

    modport master (
        output cfg_valid, cfg_iterations, cfg_period, cfg_duty, cfg_delay,
               cfg_start, cfg_shift, cfg_incr, go, abort, ag_done,
        input  cfg_ready, level, busy, seq_done, ag_iterations, ag_period,
               ag_duty, ag_delay, ag_start, ag_shift, ag_incr, ag_init, ag_run
    );
endinterface
`default_nettype wire

// File: rtl/xaddrgen_seq.sv
`default_nettype none
// ============================================================================
// Module : xaddrgen_seq
// Brief  : Queues xaddrgen configurations and replays them as init/run/done.
// Rev    : 1.0
// ============================================================================
module xaddrgen_seq #(
    parameter int MEM_ADDR_W = 10,
    parameter int PERIOD_W   = 10,
    parameter int DEPTH      = 4
) (
    input wire            clk,
    input wire            rst,
    xaddrgen_seq_if.slave bus
);
    localparam int c_AW   = $clog2(DEPTH);
    localparam int c_PTRW = c_AW + 1;
    localparam int c_EW   = 4 * MEM_ADDR_W + 3 * PERIOD_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_RUN       = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_PTRW-1:0] r_wptr;
    logic [c_PTRW-1:0] r_rptr;
    logic [c_PTRW-1:0] w_wptr_nxt;
    logic [c_PTRW-1:0] w_rptr_nxt;
    logic [c_PTRW-1:0] r_level;
    logic [c_EW-1:0]   r_mem [DEPTH];
    logic [c_EW-1:0]   w_cfg_data;
    logic [c_EW-1:0]   w_head;
    logic [c_EW-1:0]   r_ag_cfg;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_load;
    logic              w_done_nxt;
    logic              r_init;
    logic              r_run;
    logic              r_seq_done;

    assign w_cfg_data = {bus.cfg_iterations, bus.cfg_period, bus.cfg_duty, bus.cfg_delay,
                         bus.cfg_start, bus.cfg_shift, bus.cfg_incr};

    assign w_full = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                    (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_push = bus.cfg_valid && !w_full && !bus.abort;

    // Abort flushes by snapping the read pointer onto the write pointer.
    assign w_wptr_nxt = bus.abort ? r_wptr : r_wptr + c_PTRW'(w_push);
    assign w_rptr_nxt = bus.abort ? r_wptr : r_rptr + c_PTRW'(w_pop);

    // A config pushed into an otherwise drained queue is still in flight to
    // the RAM when the next LOAD is entered, so forward it from the inputs.
    assign w_head = (w_rptr_nxt == r_wptr) ? w_cfg_data : r_mem[w_rptr_nxt[c_AW-1:0]];

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.go && (r_level != '0)) begin
                    w_state_nxt = S_LOAD;
                    w_load      = 1'b1;
                end
            end
            S_LOAD:      w_state_nxt = S_RUN;
            S_RUN:       w_state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!bus.ag_done) w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.ag_done) begin
                    w_pop = 1'b1;
                    if ((r_level == c_PTRW'(1)) && !w_push) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_LOAD;
                        w_load      = 1'b1;
                    end
                end
            end
            default:     w_state_nxt = S_IDLE;
        endcase
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
            w_load      = 1'b0;
            w_pop       = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_init     <= 1'b0;
            r_run      <= 1'b0;
            r_seq_done <= 1'b0;
            r_ag_cfg   <= '0;
        end else begin
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_level    <= w_wptr_nxt - w_rptr_nxt;
            r_init     <= w_load;
            r_run      <= (w_state_nxt == S_RUN);
            r_seq_done <= w_done_nxt;
            if (w_load) r_ag_cfg <= w_head;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[c_AW-1:0]] <= w_cfg_data;
    end

    assign bus.cfg_ready = !w_full;
    assign bus.level     = r_level;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.seq_done  = r_seq_done;
    assign bus.ag_init   = r_init;
    assign bus.ag_run    = r_run;
    assign {bus.ag_iterations, bus.ag_period, bus.ag_duty, bus.ag_delay,
            bus.ag_start, bus.ag_shift, bus.ag_incr} = r_ag_cfg;
endmodule
`default_nettype wire

// File: tb/tb_xaddrgen_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_xaddrgen_seq
// Brief  : Self-checking bench for xaddrgen_seq with a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_xaddrgen_seq;
    localparam int MEM_ADDR_W = 10;
    localparam int PERIOD_W   = 10;
    localparam int DEPTH      = 4;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] iterations;
        logic [PERIOD_W-1:0]   period;
        logic [PERIOD_W-1:0]   duty;
        logic [PERIOD_W-1:0]   delay;
        logic [MEM_ADDR_W-1:0] start;
        logic [MEM_ADDR_W-1:0] shift;
        logic [MEM_ADDR_W-1:0] incr;
    } cfg_t;

    typedef struct {
        bit                    valid;
        logic [MEM_ADDR_W-1:0] start;
        bit                    exp_ready;
        int                    exp_level;
    } push_vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xaddrgen_seq_if #(.MEM_ADDR_W(MEM_ADDR_W), .PERIOD_W(PERIOD_W), .DEPTH(DEPTH)) bus ();
    xaddrgen_seq #(.MEM_ADDR_W(MEM_ADDR_W), .PERIOD_W(PERIOD_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: pending configs, whether a sequence is active, and
    // the cycle in which the current config's init pulse is due.
    cfg_t mq[$];
    bit   running = 0;
    bit   armed   = 0;
    bit   exp_sd  = 0;
    int   init_at = -100;
    cfg_t last_ld = '0;

    logic [MEM_ADDR_W-1:0] obs_starts[$];
    int n_sd = 0;

    // Generator responder: done stays high resp_hi cycles after run, then low.
    bit rand_resp = 0;
    int resp_hi = 0, resp_lo = 5;
    bit r_act = 0;
    int r_hi = 0, r_lo = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic cfg_t mk_cfg(input logic [MEM_ADDR_W-1:0] st);
        cfg_t c;
        c = '0;
        c.iterations = 2;
        c.period = 3;
        c.duty = 3;
        c.start = st;
        c.incr = 1;
        return c;
    endfunction

    task automatic drive_cfg(input cfg_t c);
        bus.cfg_iterations = c.iterations;
        bus.cfg_period     = c.period;
        bus.cfg_duty       = c.duty;
        bus.cfg_delay      = c.delay;
        bus.cfg_start      = c.start;
        bus.cfg_shift      = c.shift;
        bus.cfg_incr       = c.incr;
    endtask

    task automatic tick();
        cfg_t cur, got;
        bit   acc_push, pop, had_entries;
        @(posedge clk);
        #1;
        cyc++;
        exp_sd = 0;
        cur = {bus.cfg_iterations, bus.cfg_period, bus.cfg_duty, bus.cfg_delay,
               bus.cfg_start, bus.cfg_shift, bus.cfg_incr};
        if (rst) begin
            mq.delete();
            running = 0;
            armed   = 0;
            last_ld = '0;
        end else begin
            had_entries = (mq.size() != 0);
            acc_push = bus.cfg_valid && !bus.abort && (mq.size() < DEPTH);
            pop = 0;
            if (bus.abort) begin
                mq.delete();
                running = 0;
                armed   = 0;
            end else begin
                // Only edges after the run cycle count toward done tracking.
                if (running && (cyc - 1 >= init_at + 2)) begin
                    if (!bus.ag_done) armed = 1;
                    else if (armed)   pop = 1;
                end
                if (acc_push) mq.push_back(cur);
                if (pop) begin
                    void'(mq.pop_front());
                    armed = 0;
                    if (mq.size() == 0) begin
                        running = 0;
                        exp_sd  = 1;
                    end else begin
                        init_at = cyc;
                    end
                end else if (!running && bus.go && had_entries) begin
                    running = 1;
                    armed   = 0;
                    init_at = cyc;
                end
            end
        end
        if (running && cyc == init_at) last_ld = mq[0];
        got = {bus.ag_iterations, bus.ag_period, bus.ag_duty, bus.ag_delay,
               bus.ag_start, bus.ag_shift, bus.ag_incr};
        check("ag_init",   bus.ag_init,   running && (cyc == init_at));
        check("ag_run",    bus.ag_run,    running && (cyc == init_at + 1));
        check("seq_done",  bus.seq_done,  exp_sd);
        check("busy",      bus.busy,      running);
        check("level",     bus.level,     mq.size());
        check("cfg_ready", bus.cfg_ready, mq.size() < DEPTH);
        check("ag_cfg",    got,           last_ld);
        if (bus.ag_init)  obs_starts.push_back(bus.ag_start);
        if (bus.seq_done) n_sd++;
        if (rst) begin
            r_act = 0;
            bus.ag_done = 1'b1;
        end else if (bus.ag_run) begin
            bus.ag_done = 1'b1;
            r_hi  = rand_resp ? int'($urandom_range(0, 3)) : resp_hi;
            r_lo  = rand_resp ? int'($urandom_range(1, 6)) : resp_lo;
            r_act = 1;
        end else if (r_act) begin
            if (r_hi > 0) begin
                bus.ag_done = 1'b1;
                r_hi--;
            end else if (r_lo > 0) begin
                bus.ag_done = 1'b0;
                r_lo--;
            end else begin
                bus.ag_done = 1'b1;
                r_act = 0;
            end
        end
    endtask

    task automatic push(input cfg_t c);
        drive_cfg(c);
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic go_pulse();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (bus.busy && n < max_cyc) begin
            tick();
            n++;
        end
        check("idle_timeout", bus.busy, 1'b0);
    endtask

    task automatic clear_obs();
        obs_starts.delete();
        n_sd = 0;
    endtask

    push_vec_t tbl[DEPTH+1];

    initial begin
        for (int i = 0; i <= DEPTH; i++) begin
            tbl[i].valid     = 1'b1;
            tbl[i].start     = MEM_ADDR_W'(16 * i + 1);
            tbl[i].exp_ready = (i < DEPTH);
            tbl[i].exp_level = (i < DEPTH) ? i + 1 : DEPTH;
        end

        rst = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.go        = 1'b0;
        bus.abort     = 1'b0;
        bus.ag_done   = 1'b1;
        drive_cfg('0);
        tick();
        tick();
        check("rst_level", bus.level, 0);
        check("rst_ready", bus.cfg_ready, 1'b1);
        check("rst_busy",  bus.busy, 1'b0);
        rst = 1'b0;
        tick();

        // Single config: init at go+1 carrying start=0x10, run at go+2.
        clear_obs();
        push(mk_cfg(10'h10));
        go_pulse();
        check("t1_init", bus.ag_init, 1'b1);
        check("t1_start", bus.ag_start, 10'h10);
        tick();
        check("t1_run", bus.ag_run, 1'b1);
        wait_idle(60);
        tick();
        check("t1_sd_count", n_sd, 1);
        check("t1_level", bus.level, 0);

        // Three configs execute in order with a single seq_done.
        clear_obs();
        resp_hi = 1; resp_lo = 3;
        push(mk_cfg(10'h00));
        push(mk_cfg(10'h40));
        push(mk_cfg(10'h80));
        go_pulse();
        wait_idle(100);
        tick();
        check("t2_n_init", obs_starts.size(), 3);
        if (obs_starts.size() == 3) begin
            check("t2_start0", obs_starts[0], 10'h00);
            check("t2_start1", obs_starts[1], 10'h40);
            check("t2_start2", obs_starts[2], 10'h80);
        end
        check("t2_sd_count", n_sd, 1);

        // Overfill: the fifth push is dropped.
        foreach (tbl[i]) begin
            drive_cfg(mk_cfg(tbl[i].start));
            bus.cfg_valid = tbl[i].valid;
            check("tbl_ready", bus.cfg_ready, tbl[i].exp_ready);
            tick();
            check("tbl_level", bus.level, tbl[i].exp_level);
        end
        bus.cfg_valid = 1'b0;
        clear_obs();
        go_pulse();
        wait_idle(150);
        check("t3_n_init", obs_starts.size(), DEPTH);

        // Push during WAIT_DONE of the last entry extends the same sequence.
        clear_obs();
        resp_hi = 0; resp_lo = 8;
        push(mk_cfg(10'h00));
        push(mk_cfg(10'h40));
        push(mk_cfg(10'h80));
        go_pulse();
        for (int n = 0; n < 100 && obs_starts.size() < 3; n++) tick();
        repeat (3) tick();
        push(mk_cfg(10'hC0));
        wait_idle(100);
        tick();
        check("t4_n_init", obs_starts.size(), 4);
        if (obs_starts.size() == 4) check("t4_last", obs_starts[3], 10'hC0);
        check("t4_sd_count", n_sd, 1);

        // Abort with a simultaneous push while three entries are queued.
        resp_lo = 10;
        push(mk_cfg(10'h11));
        push(mk_cfg(10'h22));
        push(mk_cfg(10'h33));
        go_pulse();
        repeat (3) tick();
        check("t5_level_before", bus.level, 3);
        drive_cfg(mk_cfg(10'h44));
        bus.cfg_valid = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        bus.abort = 1'b0;
        check("t5_busy", bus.busy, 1'b0);
        check("t5_level", bus.level, 0);
        clear_obs();
        repeat (15) tick();
        check("t5_no_init", obs_starts.size(), 0);
        check("t5_no_sd", n_sd, 0);

        // go with an empty queue is ignored.
        clear_obs();
        go_pulse();
        repeat (3) tick();
        check("t6_busy", bus.busy, 1'b0);
        check("t6_no_init", obs_starts.size(), 0);

        // Asynchronous reset while waiting for done to drop.
        resp_hi = 6; resp_lo = 2;
        push(mk_cfg(10'h155));
        go_pulse();
        repeat (3) tick();
        check("t7_busy_before", bus.busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("t7_busy",  bus.busy, 1'b0);
        check("t7_level", bus.level, 0);
        check("t7_ready", bus.cfg_ready, 1'b1);
        check("t7_pulses", {bus.ag_init, bus.ag_run, bus.seq_done}, 3'b000);
        check("t7_start", bus.ag_start, 0);
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic against the model.
        rand_resp = 1;
        for (int n = 0; n < 1500; n++) begin
            cfg_t rc;
            logic [95:0] rb;
            rb = {$urandom(), $urandom(), $urandom()};
            rc = rb[$bits(cfg_t)-1:0];
            drive_cfg(rc);
            bus.cfg_valid = ($urandom_range(0, 99) < 40);
            bus.go        = ($urandom_range(0, 99) < 12);
            bus.abort     = ($urandom_range(0, 99) < 2);
            tick();
        end
        bus.cfg_valid = 1'b0;
        bus.go = 1'b0;
        bus.abort = 1'b0;
        wait_idle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
